// File: rtl/line_decoder_3to8_pkg.sv
// Shared widths, types and decode helpers for the 3-to-8 line decoder.
// Helpers work on the active-high form; polarity is applied by the caller.
package line_decoder_3to8_pkg;

    localparam int unsigned SEL_W = 3;
    localparam int unsigned OUT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_W-1:0] line_t;

    typedef enum logic {
        POL_ACTIVE_HIGH = 1'b0,
        POL_ACTIVE_LOW  = 1'b1
    } polarity_e;

    // Disabled decode is forced to all-zero so unknown selects cannot leak out.
    function automatic line_t onehot_decode(input sel_t sel, input logic en);
        line_t v;
        v = '0;
        if (en) begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                v[i] = (sel == sel_t'(i));
            end
        end
        return v;
    endfunction

    function automatic line_t apply_polarity(input line_t v, input polarity_e pol);
        return (pol == POL_ACTIVE_LOW) ? ~v : v;
    endfunction

    function automatic logic is_onehot0(input line_t v);
        return (v & (v - line_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/line_decoder_3to8_comb.sv
// Combinational 3-to-8 decode with output polarity selection.
// f_high is always the active-high form, exported for the self-check.
module line_decoder_comb
    import line_decoder_3to8_pkg::*;
#(
    parameter int unsigned OUT_ACTIVE_LOW = 0
) (
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] f_high,
    output logic [OUT_W-1:0] f
);

    localparam polarity_e POL = (OUT_ACTIVE_LOW != 0) ? POL_ACTIVE_LOW : POL_ACTIVE_HIGH;

    always_comb begin
        f_high = onehot_decode(sel, enable);
        f      = apply_polarity(f_high, POL);
    end

endmodule

// File: rtl/line_decoder_3to8.sv
// 3-to-8 line decoder: combinational one-hot output plus an optional
// one-cycle registered copy with valid, latched select and a one-hot self-check.
module line_decoder_3to8
    import line_decoder_3to8_pkg::*;
#(
    parameter int unsigned OUT_ACTIVE_LOW = 0,
    parameter int unsigned REG_OUT_EN     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] f,
    output logic [7:0] f_q,
    output logic       f_valid,
    output logic [2:0] sel_q,
    output logic       onehot_err
);

    localparam line_t IDLE = (OUT_ACTIVE_LOW != 0) ? line_t'('1) : line_t'('0);

    sel_t  sel;
    line_t f_high;
    logic  err_next;

    assign sel = {a, b, c};

    line_decoder_comb #(
        .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW)
    ) u_comb (
        .enable(enable),
        .sel   (sel),
        .f_high(f_high),
        .f     (f)
    );

    // Flags both a multi-hot vector and a lost selection while enabled.
    always_comb begin
        err_next = 1'b0;
        if (!is_onehot0(f_high) || (enable && (f_high == '0))) begin
            err_next = 1'b1;
        end
    end

    generate
        if (REG_OUT_EN != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    f_q        <= IDLE;
                    f_valid    <= 1'b0;
                    sel_q      <= '0;
                    onehot_err <= 1'b0;
                end else begin
                    f_q        <= f;
                    f_valid    <= enable;
                    sel_q      <= sel;
                    onehot_err <= err_next;
                end
            end
        end else begin : g_noreg
            assign f_q        = IDLE;
            assign f_valid    = 1'b0;
            assign sel_q      = '0;
            assign onehot_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_line_decoder_3to8.sv
// Scoreboard bench for line_decoder_3to8: active-high and active-low instances
// share the same stimulus; monitors pop expected values and compare.
module tb_line_decoder_3to8;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       a      = 1'b0;
    logic       b      = 1'b0;
    logic       c      = 1'b0;

    logic [7:0] f_hi, fq_hi, f_lo, fq_lo;
    logic       v_hi, v_lo, err_hi, err_lo;
    logic [2:0] sq_hi, sq_lo;

    always #5 clk = ~clk;

    line_decoder_3to8 dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .a(a), .b(b), .c(c),
        .f(f_hi), .f_q(fq_hi), .f_valid(v_hi), .sel_q(sq_hi), .onehot_err(err_hi)
    );

    line_decoder_3to8 #(.OUT_ACTIVE_LOW(1), .REG_OUT_EN(1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .a(a), .b(b), .c(c),
        .f(f_lo), .f_q(fq_lo), .f_valid(v_lo), .sel_q(sq_lo), .onehot_err(err_lo)
    );

    typedef struct packed {
        int         id;
        logic [7:0] hi;
        logic [7:0] lo;
    } comb_exp_t;

    typedef struct packed {
        int         id;
        logic [7:0] q_hi;
        logic [7:0] q_lo;
        logic       valid;
        logic [2:0] sel;
    } reg_exp_t;

    comb_exp_t comb_q[$];
    reg_exp_t  reg_q[$];
    event      comb_ev;
    event      reg_ev;
    int        checks   = 0;
    int        failures = 0;

    task automatic cmp(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, id, act, exp);
        end
    endtask

    initial begin : comb_monitor
        comb_exp_t e;
        forever begin
            @(comb_ev);
            #1;
            if (comb_q.size() != 0) begin
                e = comb_q.pop_front();
                cmp("f_hi", e.id, f_hi, e.hi);
                cmp("f_lo", e.id, f_lo, e.lo);
            end
        end
    end

    initial begin : reg_monitor
        reg_exp_t e;
        forever begin
            @(posedge clk or reg_ev);
            #1;
            if (reg_q.size() != 0) begin
                e = reg_q.pop_front();
                cmp("fq_hi", e.id, fq_hi, e.q_hi);
                cmp("fq_lo", e.id, fq_lo, e.q_lo);
                cmp("valid_hi", e.id, {7'b0, v_hi}, {7'b0, e.valid});
                cmp("valid_lo", e.id, {7'b0, v_lo}, {7'b0, e.valid});
                cmp("sel_q_hi", e.id, {5'b0, sq_hi}, {5'b0, e.sel});
                cmp("sel_q_lo", e.id, {5'b0, sq_lo}, {5'b0, e.sel});
                cmp("err_hi", e.id, {7'b0, err_hi}, 8'h00);
                cmp("err_lo", e.id, {7'b0, err_lo}, 8'h00);
            end
        end
    end

    // Apply inputs at the falling edge; registered expectation lands on the next rise.
    task automatic drive(input int id, input logic en, input logic [2:0] abc,
                         input logic [7:0] exp_hi, input bit chk_reg);
        @(negedge clk);
        enable    = en;
        {a, b, c} = abc;
        comb_q.push_back('{id: id, hi: exp_hi, lo: ~exp_hi});
        -> comb_ev;
        if (chk_reg) begin
            reg_q.push_back('{id: id, q_hi: exp_hi, q_lo: ~exp_hi, valid: en, sel: abc});
        end
        #2;
    endtask

    task automatic reset_check(input int id, input logic en, input logic [2:0] abc,
                               input logic [7:0] exp_hi);
        @(negedge clk);
        #2;
        enable    = en;
        {a, b, c} = abc;
        rst_n     = 1'b0;
        comb_q.push_back('{id: id, hi: exp_hi, lo: ~exp_hi});
        -> comb_ev;
        reg_q.push_back('{id: id, q_hi: 8'h00, q_lo: 8'hFF, valid: 1'b0, sel: 3'b000});
        -> reg_ev;
        #2;
    endtask

    task automatic hold_reset(input int id);
        @(negedge clk);
        reg_q.push_back('{id: id, q_hi: 8'h00, q_lo: 8'hFF, valid: 1'b0, sel: 3'b000});
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin : stimulus
        reset_check(0, 1'b1, 3'b111, 8'h80);
        hold_reset(1);
        release_reset();

        drive(10, 1'b0, 3'b101, 8'h00, 1'b1);
        drive(11, 1'b1, 3'b101, 8'h20, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(12 + i, 1'b1, 3'(i), sweep_exp[i], 1'b1);
        end
        drive(20, 1'b1, 3'b010, 8'h04, 1'b1);
        drive(21, 1'b0, 3'b010, 8'h00, 1'b1);

        // Enable drops between edges: f follows immediately, the next edge captures the drop.
        @(negedge clk);
        enable    = 1'b1;
        {a, b, c} = 3'b011;
        comb_q.push_back('{id: 22, hi: 8'h08, lo: 8'hF7});
        -> comb_ev;
        #2;
        enable = 1'b0;
        comb_q.push_back('{id: 23, hi: 8'h00, lo: 8'hFF});
        -> comb_ev;
        reg_q.push_back('{id: 23, q_hi: 8'h00, q_lo: 8'hFF, valid: 1'b0, sel: 3'b011});
        #2;

        drive(30, 1'b1, 3'b110, 8'h40, 1'b1);
        reset_check(31, 1'b1, 3'b110, 8'h40);
        hold_reset(32);
        release_reset();

        drive(40, 1'b0, 3'bxxx, 8'h00, 1'b0);
        drive(41, 1'b1, 3'b000, 8'h01, 1'b1);
        drive(42, 1'b1, 3'b111, 8'h80, 1'b1);
        drive(43, 1'b0, 3'b100, 8'h00, 1'b1);

        @(negedge clk);
        @(negedge clk);
        cmp("comb_q_drained", 50, 8'(comb_q.size()), 8'h00);
        cmp("reg_q_drained", 51, 8'(reg_q.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_decoder_3to8.md
Name: line_decoder_3to8

Overview:
- 3-to-8 line decoder with active-high enable: select inputs a (MSB), b, c (LSB) drive exactly one of eight output lines.
- Provides a combinational one-hot output f for glue logic.
- Provides a one-cycle registered copy f_q with a valid flag and latched select index for timing-closed consumers.
- Used as the address/line-select stage in front of register banks and mux trees.

Parameters:
- OUT_ACTIVE_LOW, 0, when 1 every output line of f and f_q is inverted: selected = 0, idle = 1.
- REG_OUT_EN, 1, when 0 f_q, f_valid and sel_q are tied to their reset values and no flops are inferred.

Ports:
- clk  input  1  rising-edge clock for the registered stage
- rst_n  input  1  asynchronous active-low reset; one clock, no other reset
- enable  input  1  active-high decode enable
- a  input  1  select bit 2 (MSB)
- b  input  1  select bit 1
- c  input  1  select bit 0 (LSB)
- f  output  8  combinational decoded lines
- f_q  output  8  registered decoded lines
- f_valid  output  1  registered enable, qualifies f_q
- sel_q  output  3  registered select index {a,b,c}
- onehot_err  output  1  registered self-check flag; 0 in a correct design

Behaviour:
- Select index: sel = {a,b,c}, so a is weight 4, b weight 2, c weight 1.
- Combinational output, with OUT_ACTIVE_LOW=0:
  - enable=1: f[sel]=1, all other bits 0; exactly one bit set.
  - enable=0: f=8'b00000000 regardless of a, b, c.
- With OUT_ACTIVE_LOW=1, f is the bitwise inverse of the active-high result (disabled gives 8'hFF).
- f is purely combinational and independent of clk and rst_n. It settles within the same delta/time step as an input change.
- Registered stage, on each rising clk edge with rst_n=1:
  - f_q <= f
  - f_valid <= enable
  - sel_q <= sel (captured even when enable=0)
- Latency from inputs to f_q, f_valid and sel_q is 1 clock.
- onehot_err <= 1 if the active-high form of f is neither one-hot nor zero, or if enable=1 and the active-high form of f is zero. Otherwise onehot_err <= 0.
- Reset, when rst_n=0 (asynchronous, immediate, independent of clk):
  - f_q = 8'h00, or 8'hFF when OUT_ACTIVE_LOW=1
  - f_valid = 0
  - sel_q = 3'b000
  - onehot_err = 0
- Reset asserted mid-operation clears the registered outputs immediately. f keeps following the inputs.
- Release of rst_n is synchronised to the design's clk domain by the integrator. The first capture happens on the first rising edge with rst_n=1.
- Input changes between clock edges are visible on f immediately but on f_q only after the next edge. There is no glitch filtering.
- X or Z on any select input while enable=1 may propagate X to f. With enable=0, f must be all-idle regardless of select values.

Decomposition:
- Shared package holds:
  - SEL_W=3, OUT_W=8 constants
  - typedef for the 3-bit select index
  - typedef for the 8-bit line vector
  - a function onehot_decode(sel, en) returning the active-high vector
- One natural sub-module: line_decoder_comb, the combinational decode plus polarity. It is instantiated once.
- The register stage, the onehot checker and the parameter muxing stay in the top module.

Test Plan:
- enable=0, a=1, b=0, c=1, wait 5 time units -> f=8'b00000000.
- enable=1, a=1, b=0, c=1 -> f=8'b00100000; after one rising clk: f_q=8'b00100000, f_valid=1, sel_q=3'b101, onehot_err=0.
- enable=1, sweep {a,b,c} 000..111 -> f = 00000001, 00000010, ..., 10000000 in order; f_q tracks with one-clock lag.
- Hold rst_n=0 with enable=1 and abc=111 -> f=8'b10000000 while f_q=0, f_valid=0, sel_q=0. Assert rst_n=0 mid-run -> registered outputs clear without a clock edge.
- OUT_ACTIVE_LOW=1: enable=1, abc=010 -> f=8'b11111011. enable=0 -> f=8'hFF. During reset -> f_q=8'hFF.
- Toggle enable 1->0 between edges with abc=011 -> f drops to 0 immediately. At the next edge: f_q=0, f_valid=0, sel_q=3'b011.
